mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single-port data/program memory between two requesters: the processor core (fetch, load and store cycles) and the program loader port.
- Serialises accesses and inserts the memory read latency.
- Returns read data and a one-cycle acknowledge to the requester that owns the access.
- Sits between the core control unit / loader and the memory macro; the core state machine advances only on c_ack.

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 16, memory word width (matches instruction register width)
- MEM_LAT, 2, cycles from mem_en asserted to mem_rdata valid; legal range 1..15

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- c_req  in  1  core request; held with fields stable until c_ack
- c_we  in  1  core write enable (1 = write, 0 = read)
- c_addr  in  ADDR_W  core address
- c_wdata  in  DATA_W  core write data
- c_ack  out  1  one-cycle pulse, core access complete
- c_rdata  out  DATA_W  last data read for the core
- l_req, l_we, l_addr, l_wdata  in  1/1/ADDR_W/DATA_W  loader request, same rules as the core fields
- l_lock  in  1  loader lock; while high, no new core grants
- l_ack  out  1  one-cycle pulse, loader access complete
- l_rdata  out  DATA_W  last data read for the loader
- mem_en  out  1  memory access strobe, high exactly one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, any time, including mid-transaction):
  - State goes to IDLE; all outputs go to 0 (both rdata registers included).
  - Internal last_owner goes to LOADER, so the core wins the first tie.
  - The in-flight access is abandoned; no ack is issued.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Eligible requesters are l_req, and c_req gated by !l_lock.
  - With exactly one eligible requester, grant it.
  - With both eligible, grant the one not equal to last_owner (round-robin).
  - On a grant: latch owner, we, addr and wdata into internal registers, set last_owner = owner, and go to ISSUE.
  - With none eligible, stay in IDLE.
- ISSUE (1 cycle):
  - mem_en = 1; mem_we, mem_addr and mem_wdata are driven from the latched values.
  - Write goes to ACK. Read loads cnt = MEM_LAT-1 and goes to WAIT.
  - mem_addr, mem_wdata and mem_we hold their last values outside ISSUE; only mem_en qualifies them.
- WAIT:
  - If cnt == 0: capture mem_rdata into the owner's rdata register and go to ACK.
  - Otherwise decrement cnt.
  - WAIT lasts exactly MEM_LAT cycles.
- ACK (1 cycle):
  - The owner's ack is high; the other ack stays low.
  - The rdata register is already updated and is stable from this cycle until the same owner's next read completes.
  - Go to IDLE.
- Latency, with the request sampled in IDLE at cycle 0:
  - Write: mem_en in cycle 1, ack in cycle 2.
  - Read: mem_en in cycle 1, ack in cycle 2+MEM_LAT.
  - Minimum spacing between grants: 3 cycles (write) or 3+MEM_LAT cycles (read).
- Requesters deassert req in the cycle after seeing ack. A req still high in the IDLE cycle after ACK is treated as a new request.
- Req dropped before ack: the latched transaction still completes and the ack still pulses.
- Request fields changing while req is high are ignored after the grant cycle.
- Writes never modify c_rdata or l_rdata.
- l_lock rises while a core access is in flight: that access completes normally. The lock affects only later grants.
- l_lock high with l_req low: the arbiter idles; the core stalls indefinitely with no ack.
- c_ack and l_ack are never high in the same cycle. mem_en is never high outside ISSUE.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, ACK=2'd3), owner encoding (OWN_CORE=1'b0, OWN_LOADER=1'b1), and the default ADDR_W/DATA_W constants shared with the core control unit.
- Single module; no sub-module. The latency counter and the round-robin pick are each a few lines.

Test Plan:
- Core read, MEM_LAT=2, memory holds 16'hA5A5 at 8'h10, c_req at cycle 0 → mem_en high only in cycle 1 with mem_addr=8'h10; c_ack high only in cycle 4; c_rdata=16'hA5A5 from cycle 4.
- Loader write of 16'h1234 to 8'h03 → mem_en&mem_we in cycle 1 with mem_wdata=16'h1234; l_ack in cycle 2; c_rdata and l_rdata unchanged.
- c_req and l_req held together continuously after reset → grants alternate core, loader, core, loader; acks never overlap; each owner gets exactly one ack per grant.
- l_lock=1, l_req=0, c_req=1 for 20 cycles → no mem_en, no c_ack, busy=0. Drop l_lock → core granted in the next IDLE cycle.
- Reset pulse during a WAIT of a core read → all outputs 0 immediately; no c_ack after reset release; the next tie goes to the core.
- MEM_LAT=1, back-to-back core reads of 8'h00 then 8'h01 → acks in cycles 3 and 7; c_rdata updates at each ack.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default widths for the memory arbiter and the core control unit.
package mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W  = 8;
  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_MEM_LAT = 2;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_CORE   = 1'b0,
    OWN_LOADER = 1'b1
  } owner_e;

  // Round-robin pick: a tie goes to whoever did not own the previous access.
  function automatic owner_e rr_pick(input logic c_elig, input logic l_elig, input owner_e last);
    owner_e pick;
    if (c_elig && l_elig) begin
      pick = (last == OWN_CORE) ? OWN_LOADER : OWN_CORE;
    end else if (c_elig) begin
      pick = OWN_CORE;
    end else begin
      pick = OWN_LOADER;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Serialises core and loader accesses onto the single-port memory, inserting the
// read latency and returning a one-cycle ack plus captured read data to the owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_ack,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0]   l_rdata_q, l_rdata_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                c_ack_q, c_ack_d;
  logic                l_ack_q, l_ack_d;
  logic                busy_q, busy_d;

  logic   c_elig;
  logic   l_elig;
  owner_e pick;

  assign c_elig = c_req && !l_lock;
  assign l_elig = l_req;
  assign pick   = rr_pick(c_elig, l_elig, last_q);

  // The memory-side registers double as the latched transaction, so they hold
  // their values outside ISSUE and only mem_en qualifies them.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    c_rdata_d   = c_rdata_q;
    l_rdata_d   = l_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    c_ack_d     = 1'b0;
    l_ack_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (c_elig || l_elig) begin
          owner_d     = pick;
          last_d      = pick;
          mem_en_d    = 1'b1;
          mem_we_d    = (pick == OWN_CORE) ? c_we    : l_we;
          mem_addr_d  = (pick == OWN_CORE) ? c_addr  : l_addr;
          mem_wdata_d = (pick == OWN_CORE) ? c_wdata : l_wdata;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_we_q) begin
          c_ack_d = (owner_q == OWN_CORE);
          l_ack_d = (owner_q == OWN_LOADER);
          state_d = ACK;
        end else begin
          cnt_d   = CNT_W'(MEM_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q == OWN_CORE) begin
            c_rdata_d = mem_rdata;
          end else begin
            l_rdata_d = mem_rdata;
          end
          c_ack_d = (owner_q == OWN_CORE);
          l_ack_d = (owner_q == OWN_LOADER);
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CORE;
      last_q      <= OWN_LOADER;
      cnt_q       <= '0;
      c_rdata_q   <= '0;
      l_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      c_ack_q     <= 1'b0;
      l_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      c_rdata_q   <= c_rdata_d;
      l_rdata_q   <= l_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      c_ack_q     <= c_ack_d;
      l_ack_q     <= l_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign c_ack     = c_ack_q;
  assign l_ack     = l_ack_q;
  assign c_rdata   = c_rdata_q;
  assign l_rdata   = l_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule
